// File: rtl/life_row_engine.sv
// life_row_engine
// Streaming next-generation engine for Life-like cellular automata. One frame
// of HEIGHT rows (WIDTH cells each) streams in over in_valid/in_ready, and the
// next generation streams out one row at a time over out_valid/out_ready.
// Birth/survive rules are programmable and latched at the start of each frame.
// The boundary is dead (WRAP=0) or toroidal (WRAP=1).
//
// Ports
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   rule_birth[8:0]          bit n: dead cell with n live neighbours is born
//   rule_survive[8:0]        bit n: live cell with n live neighbours survives
//   in_valid/in_ready/in_row input row stream, rows 0..HEIGHT-1 in order
//   out_valid/out_ready      output row handshake
//   out_row/out_idx/out_last next-generation row, its index, end-of-frame flag
//   gen_count[15:0]          number of completed frames (wraps)
module life_row_engine #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 48,
  parameter int WRAP   = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [8:0]                rule_birth,
  input  logic [8:0]                rule_survive,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_row,
  output logic [$clog2(HEIGHT)-1:0] out_idx,
  output logic                      out_last,
  output logic [15:0]               gen_count
);

  localparam int IDX_W = $clog2(HEIGHT);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(HEIGHT - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Extend a row by one column on each side; ext[i+1] is column i, so ext[0]
  // is the left neighbour of column 0 and ext[WIDTH+1] the right neighbour of
  // column WIDTH-1.
  function automatic logic [WIDTH+1:0] pad_row(input logic [WIDTH-1:0] row);
    logic [WIDTH+1:0] ext;
    ext = {1'b0, row, 1'b0};
    if (WRAP != 0) begin
      ext[0]       = row[WIDTH-1];
      ext[WIDTH+1] = row[0];
    end else begin
      ext[0]       = 1'b0;
      ext[WIDTH+1] = 1'b0;
    end
    return ext;
  endfunction

  // Apply the birth/survive rule to every cell of the center row.
  function automatic logic [WIDTH-1:0] next_row(
    input logic [WIDTH-1:0] above,
    input logic [WIDTH-1:0] center,
    input logic [WIDTH-1:0] below,
    input logic [8:0]       birth,
    input logic [8:0]       survive
  );
    logic [WIDTH+1:0] ea;
    logic [WIDTH+1:0] ec;
    logic [WIDTH+1:0] eb;
    logic [WIDTH-1:0] res;
    logic [3:0]       n;
    ea  = pad_row(above);
    ec  = pad_row(center);
    eb  = pad_row(below);
    res = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      n = {3'b000, ea[i]} + {3'b000, ea[i+1]} + {3'b000, ea[i+2]}
        + {3'b000, ec[i]}                     + {3'b000, ec[i+2]}
        + {3'b000, eb[i]} + {3'b000, eb[i+1]} + {3'b000, eb[i+2]};
      res[i] = ec[i+1] ? survive[n] : birth[n];
    end
    return res;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             flush_step_r;
  logic             flush_step_nxt_s;
  logic [IDX_W-1:0] row_cnt_r;
  logic [WIDTH-1:0] prev2_r;
  logic [WIDTH-1:0] prev1_r;
  logic [WIDTH-1:0] row0_r;
  logic [WIDTH-1:0] row1_r;
  logic [8:0]       birth_r;
  logic [8:0]       survive_r;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_row_r;
  logic [IDX_W-1:0] out_idx_r;
  logic             out_last_r;
  logic [15:0]      gen_count_r;

  logic             out_free_s;
  logic             accept_s;
  logic             load_s;
  logic [WIDTH-1:0] above_s;
  logic [WIDTH-1:0] center_s;
  logic [WIDTH-1:0] below_s;
  logic [IDX_W-1:0] load_idx_s;
  logic             load_last_s;

  // The output register can take a new row when empty or being drained now.
  assign out_free_s = !out_valid_r || out_ready;
  // Gated by reset_n so the source sees no acceptance while reset is held.
  assign in_ready   = reset_n && (state_r == FILL) && out_free_s;
  assign accept_s   = in_valid && in_ready;

  assign out_valid  = out_valid_r;
  assign out_row    = out_row_r;
  assign out_idx    = out_idx_r;
  assign out_last   = out_last_r;
  assign gen_count  = gen_count_r;

  // Next-state logic and selection of the window feeding the output register.
  always_comb begin
    state_nxt_s      = state_r;
    flush_step_nxt_s = flush_step_r;
    load_s           = 1'b0;
    above_s          = {WIDTH{1'b0}};
    center_s         = {WIDTH{1'b0}};
    below_s          = {WIDTH{1'b0}};
    load_idx_s       = {IDX_W{1'b0}};
    load_last_s      = 1'b0;
    case (state_r)
      FILL: begin
        flush_step_nxt_s = 1'b0;
        if (accept_s) begin
          // Incoming row k completes the window for row k-1.
          center_s   = prev1_r;
          below_s    = in_row;
          load_idx_s = row_cnt_r - IDX_W'(1);
          if (row_cnt_r >= IDX_W'(2)) begin
            above_s = prev2_r;
          end else begin
            above_s = {WIDTH{1'b0}};
          end
          if (WRAP != 0) begin
            // Row 0 needs row HEIGHT-1 above it, so it is deferred to FLUSH.
            load_s = (row_cnt_r >= IDX_W'(2));
          end else begin
            load_s = (row_cnt_r != {IDX_W{1'b0}});
          end
          if (row_cnt_r == LAST_ROW) begin
            state_nxt_s = FLUSH;
          end else begin
            state_nxt_s = FILL;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      FLUSH: begin
        if (out_free_s) begin
          load_s = 1'b1;
          if ((WRAP != 0) && flush_step_r) begin
            // Closing row 0: above is the last row, below is the saved row 1.
            above_s          = prev1_r;
            center_s         = row0_r;
            below_s          = row1_r;
            load_idx_s       = {IDX_W{1'b0}};
            load_last_s      = 1'b1;
            flush_step_nxt_s = 1'b0;
            state_nxt_s      = FILL;
          end else if (WRAP != 0) begin
            above_s          = prev2_r;
            center_s         = prev1_r;
            below_s          = row0_r;
            load_idx_s       = LAST_ROW;
            load_last_s      = 1'b0;
            flush_step_nxt_s = 1'b1;
            state_nxt_s      = FLUSH;
          end else begin
            above_s          = prev2_r;
            center_s         = prev1_r;
            below_s          = {WIDTH{1'b0}};
            load_idx_s       = LAST_ROW;
            load_last_s      = 1'b1;
            flush_step_nxt_s = 1'b0;
            state_nxt_s      = FILL;
          end
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s      = FILL;
        flush_step_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, row window, saved wrap rows and latched rules.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= FILL;
      flush_step_r <= 1'b0;
      row_cnt_r    <= {IDX_W{1'b0}};
      prev2_r      <= {WIDTH{1'b0}};
      prev1_r      <= {WIDTH{1'b0}};
      row0_r       <= {WIDTH{1'b0}};
      row1_r       <= {WIDTH{1'b0}};
      birth_r      <= 9'h000;
      survive_r    <= 9'h000;
    end else begin
      state_r      <= state_nxt_s;
      flush_step_r <= flush_step_nxt_s;
      if (accept_s) begin
        prev2_r <= prev1_r;
        prev1_r <= in_row;
        if (row_cnt_r == {IDX_W{1'b0}}) begin
          row0_r    <= in_row;
          birth_r   <= rule_birth;
          survive_r <= rule_survive;
        end
        if (row_cnt_r == IDX_W'(1)) begin
          row1_r <= in_row;
        end
        if (row_cnt_r == LAST_ROW) begin
          row_cnt_r <= {IDX_W{1'b0}};
        end else begin
          row_cnt_r <= row_cnt_r + IDX_W'(1);
        end
      end
    end
  end

  // Output register: load beats drain so consume+load in one cycle keeps rate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_row_r   <= {WIDTH{1'b0}};
      out_idx_r   <= {IDX_W{1'b0}};
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_row_r   <= next_row(above_s, center_s, below_s, birth_r, survive_r);
      out_idx_r   <= load_idx_s;
      out_last_r  <= load_last_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Frame counter advances when the final row of a frame is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_count_r <= 16'd0;
    end else if (out_valid_r && out_ready && out_last_r) begin
      gen_count_r <= gen_count_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_life_row_engine.sv
// Bench for life_row_engine on an 8x8 grid. Two instances (dead edge and
// toroidal) share the stimulus; sel routes the handshake to one of them.
module tb_life_row_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [8:0]    rule_birth;
  logic [8:0]    rule_survive;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  in_row;
  logic          sel;

  logic          iv0, iv1, ir0, ir1, ov0, ov1, ordy0, ordy1, ol0, ol1;
  logic [W-1:0]  orow0, orow1;
  logic [IW-1:0] oidx0, oidx1;
  logic [15:0]   gc0, gc1;

  assign iv0   = in_valid && !sel;
  assign iv1   = in_valid && sel;
  assign ordy0 = sel ? 1'b1 : out_ready;
  assign ordy1 = sel ? out_ready : 1'b1;

  logic          m_in_ready, m_out_valid, m_out_last;
  logic [W-1:0]  m_out_row;
  logic [IW-1:0] m_out_idx;
  logic [15:0]   m_gen;
  assign m_in_ready  = sel ? ir1 : ir0;
  assign m_out_valid = sel ? ov1 : ov0;
  assign m_out_last  = sel ? ol1 : ol0;
  assign m_out_row   = sel ? orow1 : orow0;
  assign m_out_idx   = sel ? oidx1 : oidx0;
  assign m_gen       = sel ? gc1 : gc0;

  life_row_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(0)) dut_dead (
    .clk(clk), .reset_n(reset_n), .rule_birth(rule_birth), .rule_survive(rule_survive),
    .in_valid(iv0), .in_ready(ir0), .in_row(in_row),
    .out_valid(ov0), .out_ready(ordy0), .out_row(orow0), .out_idx(oidx0),
    .out_last(ol0), .gen_count(gc0));

  life_row_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .rule_birth(rule_birth), .rule_survive(rule_survive),
    .in_valid(iv1), .in_ready(ir1), .in_row(in_row),
    .out_valid(ov1), .out_ready(ordy1), .out_row(orow1), .out_idx(oidx1),
    .out_last(ol1), .gen_count(gc1));

  int checks   = 0;
  int failures = 0;
  int gen_exp [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] cur_frame [H];
  logic [W-1:0] exp_frame [H];
  logic [W-1:0] fb_frame  [H];

  // Reference: direct neighbourhood count over the whole frame.
  function automatic int ref_cell(input int r, input int c, input bit wrap);
    int rr, cc;
    rr = r;
    cc = c;
    if (wrap) begin
      rr = (r + H) % H;
      cc = (c + W) % W;
    end else if (r < 0 || r >= H || c < 0 || c >= W) begin
      return 0;
    end
    return int'(cur_frame[rr][cc]);
  endfunction

  task automatic ref_step(input bit wrap, input logic [8:0] b, input logic [8:0] s);
    int n;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += ref_cell(r + dr, c + dc, wrap);
        exp_frame[r][c] = cur_frame[r][c] ? s[n] : b[n];
      end
    end
  endtask

  // Stream cur_frame into the selected instance, collect the output frame into
  // fb_frame and compare against the reference.
  task automatic run_frame(input bit wrap, input int ready_pct, input int chg_row,
                           input logic [8:0] b2, input logic [8:0] s2);
    int            sent, got, cyc, last_cyc, eidx;
    bit            stalled;
    logic [W-1:0]  hold_row;
    logic [IW-1:0] hold_idx;
    logic          hold_last;
    logic [W-1:0]  q_row [$];
    int            q_idx [$];
    bit            q_last [$];
    sel = wrap;
    ref_step(wrap, rule_birth, rule_survive);
    sent = 0; got = 0; cyc = 0; last_cyc = -1; stalled = 1'b0;
    hold_row = '0; hold_idx = '0; hold_last = 1'b0;
    while (got < H && cyc < 400) begin
      @(negedge clk);
      if (sent == chg_row) begin
        rule_birth   = b2;
        rule_survive = s2;
      end
      in_valid  = (sent < H);
      in_row    = (sent < H) ? cur_frame[sent] : '0;
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (stalled) begin
        check_eq("stall_valid", m_out_valid, 1);
        check_eq("stall_row", m_out_row, hold_row);
        check_eq("stall_idx", m_out_idx, hold_idx);
        check_eq("stall_last", m_out_last, hold_last);
      end
      if (in_valid && m_in_ready) sent++;
      if (m_out_valid && out_ready) begin
        q_row.push_back(m_out_row);
        q_idx.push_back(int'(m_out_idx));
        q_last.push_back(m_out_last);
        got++;
        if (got == H) last_cyc = cyc;
      end
      stalled   = m_out_valid && !out_ready;
      hold_row  = m_out_row;
      hold_idx  = m_out_idx;
      hold_last = m_out_last;
      cyc++;
    end
    check_eq("row_count", got, H);
    for (int i = 0; i < got; i++) begin
      eidx = wrap ? ((i == H - 1) ? 0 : i + 1) : i;
      check_eq("out_idx", q_idx[i], eidx);
      check_eq("out_row", q_row[i], exp_frame[eidx]);
      check_eq("out_last", q_last[i], (i == H - 1));
      fb_frame[q_idx[i] % H] = q_row[i];
    end
    if (ready_pct >= 100) check_eq("frame_latency", last_cyc, wrap ? H + 2 : H + 1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    gen_exp[wrap] = gen_exp[wrap] + 1;
    check_eq("gen_count", m_gen, gen_exp[wrap]);
    check_eq("idle_valid", m_out_valid, 0);
  endtask

  task automatic clear_frame();
    for (int r = 0; r < H; r++) cur_frame[r] = '0;
  endtask

  task automatic random_frame();
    for (int r = 0; r < H; r++) cur_frame[r] = W'($urandom);
  endtask

  initial begin
    sel = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
    rule_birth = 9'h008; rule_survive = 9'h00C; reset_n = 1'b0;
    gen_exp[0] = 0; gen_exp[1] = 0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_in_ready", m_in_ready, 0);
    check_eq("rst_out_valid", m_out_valid, 0);
    check_eq("rst_out_row", m_out_row, 0);
    check_eq("rst_out_idx", m_out_idx, 0);
    check_eq("rst_out_last", m_out_last, 0);
    check_eq("rst_gen", m_gen, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rel_in_ready", m_in_ready, 1);

    // Blinker on row 3, dead edge.
    clear_frame();
    cur_frame[3] = 8'b0001_1100;
    run_frame(1'b0, 100, -1, 9'h008, 9'h00C);
    check_eq("blink_r2", fb_frame[2], 8'h08);
    check_eq("blink_r3", fb_frame[3], 8'h08);
    check_eq("blink_r4", fb_frame[4], 8'h08);
    check_eq("blink_r5", fb_frame[5], 8'h00);

    // Vertical blinker on column 0: dead edge vs toroidal.
    clear_frame();
    cur_frame[0] = 8'h01; cur_frame[1] = 8'h01; cur_frame[2] = 8'h01;
    run_frame(1'b0, 100, -1, 9'h008, 9'h00C);
    check_eq("edge_dead_r1", fb_frame[1], 8'b0000_0011);
    run_frame(1'b1, 100, -1, 9'h008, 9'h00C);
    check_eq("edge_wrap_r1", fb_frame[1], 8'b1000_0011);

    // Toroidal glider returns home after 32 generations.
    clear_frame();
    cur_frame[0] = 8'h02; cur_frame[1] = 8'h04; cur_frame[2] = 8'h07;
    for (int g = 0; g < 32; g++) begin
      run_frame(1'b1, 100, -1, 9'h008, 9'h00C);
      for (int r = 0; r < H; r++) cur_frame[r] = fb_frame[r];
    end
    check_eq("glider_r0", cur_frame[0], 8'h02);
    check_eq("glider_r1", cur_frame[1], 8'h04);
    check_eq("glider_r2", cur_frame[2], 8'h07);
    check_eq("glider_r3", cur_frame[3], 8'h00);

    // Random frames and rules under 50% backpressure on both instances.
    for (int k = 0; k < 8; k++) begin
      rule_birth   = 9'($urandom_range(511));
      rule_survive = 9'($urandom_range(511));
      random_frame();
      run_frame(k[0], 50, -1, 9'h008, 9'h00C);
    end

    // Rules switched to HighLife mid-frame take effect on the next frame only.
    rule_birth = 9'h008; rule_survive = 9'h00C;
    random_frame();
    run_frame(1'b0, 100, 4, 9'h048, 9'h00C);
    random_frame();
    run_frame(1'b0, 100, -1, 9'h048, 9'h00C);
    random_frame();
    run_frame(1'b1, 70, -1, 9'h048, 9'h00C);
    rule_birth = 9'h008; rule_survive = 9'h00C;

    // Reset after row 5 of a frame.
    sel = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_row = W'($urandom); out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_eq("mid_rst_valid", m_out_valid, 0);
    check_eq("mid_rst_gen", m_gen, 0);
    check_eq("mid_rst_in_ready", m_in_ready, 0);
    gen_exp[0] = 0; gen_exp[1] = 0;
    @(negedge clk);
    reset_n = 1'b1;
    random_frame();
    run_frame(1'b0, 100, -1, 9'h008, 9'h00C);
    random_frame();
    run_frame(1'b1, 60, -1, 9'h008, 9'h00C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
